coriolis_ker0_ostream_join: RTL and testbench

Downstream consumer of the coriolis kernel top. It takes the kernel's two output streams, `un` and `vn`, under a single shared valid. It joins each pair into one `2*STREAMW` word and buffers it in a circular FIFO. Words are presented on a single valid/ready output stream towards the memory/write-back stage. The block also counts delivered words and raises a sticky `done` after `NITEMS` words have been drained.

---
 rtl/coriolis_ker0_ostream_join_pkg.sv | 19 +
 rtl/coriolis_ker0_ostream_join_ostream_fifo.sv | 81 ++++++++
 rtl/coriolis_ker0_ostream_join.sv | 93 +++++++++
 tb/tb_coriolis_ker0_ostream_join.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/coriolis_ker0_ostream_join_pkg.sv
// Shared definitions for the coriolis kernel-0 output-stream join and the
// write-back stage that unpacks its words.
package coriolis_ker0_ostream_join_pkg;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int unsigned fill_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Which stream lands in the upper half of a joined word.
  typedef enum logic {
    PACK_VN_MSB = 1'b0,
    PACK_UN_MSB = 1'b1
  } pack_order_e;

  // The write-back stage relies on this to split words back into un/vn.
  localparam pack_order_e PAIR_PACK_ORDER = PACK_UN_MSB;

endpackage

// File: rtl/coriolis_ker0_ostream_join_ostream_fifo.sv
// Generic DEPTH x W synchronous circular FIFO with valid/ready on both sides.
// Input ready is derived from registered occupancy only, so a full FIFO
// refuses a push even when a pop happens in the same cycle.
module ostream_fifo
  import coriolis_ker0_ostream_join_pkg::*;
#(
  parameter int unsigned W     = 68,
  parameter int unsigned DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [W-1:0]                   in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [W-1:0]                   out_data,
  input  logic                           out_ready,
  output logic [fill_width(DEPTH)-1:0]   fill
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = fill_width(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          push, pop;

  // Handshake decode and next-state for pointers and occupancy.
  always_comb begin
    in_ready  = (fill_q != FW'(DEPTH));
    out_valid = (fill_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;

    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fill_d = fill_q;

    if (push) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end

    unique case ({push, pop})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards buffered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fill_q <= fill_d;
    end
  end

  // Storage array; contents are left untouched by reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= in_data;
    end
  end

  // Head word and occupancy presented to the consumer.
  always_comb begin
    out_data = mem_q[rptr_q];
    fill     = fill_q;
  end

endmodule

// File: rtl/coriolis_ker0_ostream_join.sv
// Joins the coriolis kernel-0 un/vn output streams into one word per
// transfer, buffers them, and counts words delivered to write-back.
module coriolis_ker0_ostream_join
  import coriolis_ker0_ostream_join_pkg::*;
#(
  parameter int unsigned STREAMW = 34,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned NITEMS  = 1024,
  parameter int unsigned CNTW    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ivalid,
  input  logic [STREAMW-1:0]            un_s0,
  input  logic [STREAMW-1:0]            vn_s0,
  output logic                          oready_un_s0,
  output logic                          oready_vn_s0,
  output logic                          ovalid,
  output logic [2*STREAMW-1:0]          odata,
  input  logic                          oready,
  output logic [fill_width(DEPTH)-1:0]  fill,
  output logic [CNTW-1:0]               count,
  output logic                          done
);

  localparam logic [CNTW-1:0] NITEMS_C = CNTW'(NITEMS);

  logic [2*STREAMW-1:0] join_word;
  logic                 fifo_in_ready;
  logic                 fifo_out_valid;
  logic                 out_xfer;
  logic [CNTW-1:0]      count_q, count_d;
  logic                 done_q, done_d;

  // Pack the stream pair in the order the write-back stage expects.
  always_comb begin
    if (PAIR_PACK_ORDER == PACK_UN_MSB) begin
      join_word = {un_s0, vn_s0};
    end else begin
      join_word = {vn_s0, un_s0};
    end
  end

  ostream_fifo #(
    .W     (2 * STREAMW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (ivalid),
    .in_data   (join_word),
    .in_ready  (fifo_in_ready),
    .out_valid (fifo_out_valid),
    .out_data  (odata),
    .out_ready (oready),
    .fill      (fill)
  );

  // Both kernel streams share one valid, so they share one ready too.
  always_comb begin
    oready_un_s0 = fifo_in_ready;
    oready_vn_s0 = fifo_in_ready;
    ovalid       = fifo_out_valid;
  end

  // Saturating transfer counter and sticky completion flag.
  always_comb begin
    out_xfer = fifo_out_valid && oready;
    count_d  = count_q;
    if (out_xfer && (count_q != NITEMS_C)) begin
      count_d = count_q + CNTW'(1);
    end
    done_d = done_q || (count_q == NITEMS_C);
  end

  // Counter and done registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Expose counter state.
  always_comb begin
    count = count_q;
    done  = done_q;
  end

endmodule

// File: tb/tb_coriolis_ker0_ostream_join.sv
// Directed bench for coriolis_ker0_ostream_join with an in-order scoreboard.
module tb_coriolis_ker0_ostream_join;

  localparam int unsigned STREAMW = 34;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned NITEMS  = 8;
  localparam int unsigned CNTW    = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ivalid;
  logic [STREAMW-1:0]   un_s0, vn_s0;
  logic                 oready_un_s0, oready_vn_s0;
  logic                 ovalid;
  logic [2*STREAMW-1:0] odata;
  logic                 oready;
  logic [4:0]           fill;
  logic [CNTW-1:0]      count;
  logic                 done;

  int checks   = 0;
  int failures = 0;

  logic [67:0] sb[$];
  int          mfill;
  int          mcount;
  logic        mdone;
  int          npop;

  coriolis_ker0_ostream_join #(
    .STREAMW (STREAMW),
    .DEPTH   (DEPTH),
    .NITEMS  (NITEMS),
    .CNTW    (CNTW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ivalid       (ivalid),
    .un_s0        (un_s0),
    .vn_s0        (vn_s0),
    .oready_un_s0 (oready_un_s0),
    .oready_vn_s0 (oready_vn_s0),
    .ovalid       (ovalid),
    .odata        (odata),
    .oready       (oready),
    .fill         (fill),
    .count        (count),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs against the model, advance the
  // model with the handshakes that will happen at the edge, then check state.
  task automatic tick(input string tag);
    logic push, pop;
    chk({tag, "_rdy_un"}, 68'(oready_un_s0), 68'(mfill != 16));
    chk({tag, "_rdy_vn"}, 68'(oready_vn_s0), 68'(mfill != 16));
    chk({tag, "_ovalid"}, 68'(ovalid), 68'(mfill != 0));
    pop  = (mfill != 0) && oready;
    push = ivalid && (mfill != 16);
    if (ovalid && oready) npop++;
    if (pop) begin
      chk({tag, "_odata"}, odata, sb[0]);
      void'(sb.pop_front());
    end
    if (push) sb.push_back({un_s0, vn_s0});
    mdone = mdone | (mcount == NITEMS);
    if (pop && mcount != NITEMS) mcount++;
    mfill = mfill + int'(push) - int'(pop);
    @(posedge clk);
    #1;
    chk({tag, "_fill"},  68'(fill),  68'(mfill));
    chk({tag, "_count"}, 68'(count), 68'(mcount));
    chk({tag, "_done"},  68'(done),  68'(mdone));
  endtask

  task automatic do_reset(input string tag);
    rst    = 1'b1;
    ivalid = 1'b0;
    oready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    mfill  = 0;
    mcount = 0;
    mdone  = 1'b0;
    chk({tag, "_ovalid"}, 68'(ovalid),       68'(0));
    chk({tag, "_rdy_un"}, 68'(oready_un_s0), 68'(1));
    chk({tag, "_rdy_vn"}, 68'(oready_vn_s0), 68'(1));
    chk({tag, "_fill"},   68'(fill),         68'(0));
    chk({tag, "_count"},  68'(count),        68'(0));
    chk({tag, "_done"},   68'(done),         68'(0));
  endtask

  initial begin
    rst = 1'b1; ivalid = 1'b0; oready = 1'b0; un_s0 = '0; vn_s0 = '0;
    npop = 0;
    @(posedge clk);
    do_reset("reset");

    // Single word: visible the cycle after the push, {un, vn} order.
    ivalid = 1'b1; un_s0 = 34'h1; vn_s0 = 34'h2; oready = 1'b1;
    tick("single_push");
    ivalid = 1'b0;
    chk("single_ovalid", 68'(ovalid), 68'(1));
    chk("single_odata", odata, 68'h0_0000_0004_0000_0002);
    tick("single_pop");
    chk("single_count", 68'(count), 68'(1));

    // Fill to full with backpressure, then refuse a 17th word.
    oready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ivalid = 1'b1; un_s0 = 34'(i); vn_s0 = 34'(i);
      tick("fill_push");
    end
    chk("full_fill", 68'(fill), 68'(16));
    chk("full_rdy", 68'(oready_un_s0), 68'(0));
    un_s0 = 34'h3_0000_0099; vn_s0 = 34'h3_0000_0099;
    tick("full_reject");
    chk("full_still16", 68'(fill), 68'(16));
    ivalid = 1'b0; oready = 1'b1;
    chk("drain_first", odata, 68'h0);
    tick("drain0");
    chk("drain_rdy_back", 68'(oready_un_s0), 68'(1));
    for (int i = 1; i < 16; i++) begin
      chk("drain_order", odata, {34'(i), 34'(i)});
      tick("drain");
    end
    chk("drain_empty", 68'(fill), 68'(0));

    // Streaming: one word per cycle, occupancy stays at one.
    do_reset("reset_stream");
    npop = 0;
    ivalid = 1'b1; oready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      un_s0 = 34'(i + 1000); vn_s0 = 34'(i * 3);
      tick("stream");
      chk("stream_fill_le1", 68'(fill <= 5'd1), 68'(1));
    end
    chk("stream_throughput", 68'(npop), 68'(99));

    // Done: set one cycle after count reaches NITEMS, count saturates.
    do_reset("reset_done");
    oready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ivalid = 1'b1; un_s0 = 34'(i + 50); vn_s0 = 34'(i + 70);
      tick("done_fill");
    end
    ivalid = 1'b0; oready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick("done_drain");
      chk("done_count", 68'(count), 68'((i < 8) ? i : 8));
      chk("done_flag", 68'(done), 68'(i >= 9));
    end

    // Random backpressure against the scoreboard.
    do_reset("reset_rand");
    for (int i = 0; i < 2000; i++) begin
      ivalid = 1'($urandom_range(0, 1));
      oready = 1'($urandom_range(0, 1));
      un_s0  = 34'($urandom);
      vn_s0  = 34'($urandom);
      tick("rand");
      chk("rand_fill_le16", 68'(fill <= 5'd16), 68'(1));
    end

    // Reset mid-stream with fill = 5 and count = 3.
    do_reset("reset_mid_pre");
    oready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ivalid = 1'b1; un_s0 = 34'(i + 200); vn_s0 = 34'(i + 300);
      tick("mid_fill");
    end
    ivalid = 1'b0; oready = 1'b1;
    for (int i = 0; i < 3; i++) tick("mid_pop");
    chk("mid_fill5", 68'(fill), 68'(5));
    chk("mid_count3", 68'(count), 68'(3));
    do_reset("reset_mid");
    ivalid = 1'b1; un_s0 = 34'h0AAA; vn_s0 = 34'h0555; oready = 1'b1;
    tick("mid_newpush");
    ivalid = 1'b0;
    chk("mid_new_ovalid", 68'(ovalid), 68'(1));
    chk("mid_new_odata", odata, {34'h0AAA, 34'h0555});
    tick("mid_newpop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
